// File: rtl/if_id_elastic_reg.sv
// if_id_elastic_reg: DEPTH-entry in-order IF/ID elastic buffer with flush and occupancy.
// Define IF_ID_BUBBLE_NOP_EN to drive NOP_WORD and pc 0 whenever the head is empty.
module if_id_elastic_reg #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH = 32,
    parameter int DEPTH = 2,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD = '0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      hit,
    input  logic [PC_WIDTH-1:0]       next_pc,
    input  logic [INSTR_WIDTH-1:0]    instruction,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic                      out_ready,
    output logic                      hit_out,
    output logic [PC_WIDTH-1:0]       next_pc_out,
    output logic [INSTR_WIDTH-1:0]    instruction_out,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_WIDTH-1:0]    pc_mem  [DEPTH];
    logic [INSTR_WIDTH-1:0] ins_mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   push, pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // in_ready depends on registered count only, never on out_ready
    assign in_ready = count < CW'(DEPTH);
    assign hit_out  = count != '0;
    assign push     = hit & in_ready;
    assign pop      = hit_out & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]  <= '0;
                ins_mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]  <= next_pc;
                ins_mem[wr_ptr] <= instruction;
                wr_ptr          <= inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef IF_ID_BUBBLE_NOP_EN
    assign next_pc_out     = hit_out ? pc_mem[rd_ptr] : '0;
    assign instruction_out = hit_out ? ins_mem[rd_ptr] : NOP_WORD;
`else
    assign next_pc_out     = pc_mem[rd_ptr];
    assign instruction_out = ins_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_if_id_elastic_reg.sv
// tb_if_id_elastic_reg: table vectors plus randomized traffic against a queue model,
// run on a DEPTH=2 and a DEPTH=4 instance sharing one input stream.
module tb_if_id_elastic_reg;
    localparam logic [31:0] NOP = 32'h0;

    logic clock = 0, reset_n = 0, hit = 0, flush = 0, out_ready = 0;
    logic [31:0] next_pc = 0, instruction = 0;
    logic        ir2, ho2, ir4, ho4;
    logic [31:0] pc2, in2, pc4, in4;
    logic [1:0]  c2;
    logic [2:0]  c4;

    int vectors = 0, miscompares = 0;

    always #5 clock = ~clock;

    if_id_elastic_reg #(.DEPTH(2)) u2 (
        .clock(clock), .reset_n(reset_n), .hit(hit), .next_pc(next_pc),
        .instruction(instruction), .in_ready(ir2), .flush(flush), .out_ready(out_ready),
        .hit_out(ho2), .next_pc_out(pc2), .instruction_out(in2), .count(c2));

    if_id_elastic_reg #(.DEPTH(4)) u4 (
        .clock(clock), .reset_n(reset_n), .hit(hit), .next_pc(next_pc),
        .instruction(instruction), .in_ready(ir4), .flush(flush), .out_ready(out_ready),
        .hit_out(ho4), .next_pc_out(pc4), .instruction_out(in4), .count(c4));

    typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t q2[$], q4[$];
    bit seen2, seen4;

    typedef struct {
        logic hit, flush, ordy;
        logic [31:0] pc, ins;
        logic e_hit, e_ir;
        int   e_cnt;
        logic chk_data;
        logic [31:0] e_pc, e_ins;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q2.delete();
        q4.delete();
        seen2 = 0;
        seen4 = 0;
    endtask

    task automatic model_edge();
        bit p2 = hit && q2.size() < 2;
        bit o2 = out_ready && q2.size() > 0;
        bit p4 = hit && q4.size() < 4;
        bit o4 = out_ready && q4.size() > 0;
        if (flush) begin
            q2.delete();
            q4.delete();
        end else begin
            if (o2) void'(q2.pop_front());
            if (p2) begin q2.push_back({next_pc, instruction}); seen2 = 1; end
            if (o4) void'(q4.pop_front());
            if (p4) begin q4.push_back({next_pc, instruction}); seen4 = 1; end
        end
    endtask

    task automatic check_dut();
        chk("u2.hit_out", ho2, q2.size() != 0);
        chk("u2.count", c2, q2.size());
        chk("u2.in_ready", ir2, q2.size() < 2);
        if (q2.size() != 0) begin
            chk("u2.pc", pc2, q2[0].pc);
            chk("u2.instr", in2, q2[0].ins);
        end else begin
`ifdef IF_ID_BUBBLE_NOP_EN
            chk("u2.nop_pc", pc2, 0);
            chk("u2.nop_instr", in2, NOP);
`else
            if (!seen2) begin
                chk("u2.rst_pc", pc2, 0);
                chk("u2.rst_instr", in2, 0);
            end
`endif
        end
        chk("u4.hit_out", ho4, q4.size() != 0);
        chk("u4.count", c4, q4.size());
        chk("u4.in_ready", ir4, q4.size() < 4);
        if (q4.size() != 0) begin
            chk("u4.pc", pc4, q4[0].pc);
            chk("u4.instr", in4, q4[0].ins);
        end else begin
`ifdef IF_ID_BUBBLE_NOP_EN
            chk("u4.nop_pc", pc4, 0);
            chk("u4.nop_instr", in4, NOP);
`else
            if (!seen4) begin
                chk("u4.rst_pc", pc4, 0);
                chk("u4.rst_instr", in4, 0);
            end
`endif
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_dut();
    endtask

    task automatic drive(input logic h, input logic f, input logic o,
                         input logic [31:0] p, input logic [31:0] i);
        hit = h; flush = f; out_ready = o; next_pc = p; instruction = i;
    endtask

    task automatic addv(input logic h, f, o, input logic [31:0] p, i,
                        input logic eh, eir, input int ec, input logic cd,
                        input logic [31:0] ep, ei);
        vec_t v;
        v.hit = h; v.flush = f; v.ordy = o; v.pc = p; v.ins = i;
        v.e_hit = eh; v.e_ir = eir; v.e_cnt = ec; v.chk_data = cd; v.e_pc = ep; v.e_ins = ei;
        tbl.push_back(v);
    endtask

    initial begin
        // DEPTH=2 directed sequence: stream, back-pressure, full+pop, simultaneous, flush
        addv(1,0,1, 32'h04, 32'h20080001, 1,1,1, 1, 32'h04, 32'h20080001);
        addv(1,0,1, 32'h08, 32'h20090002, 1,1,1, 1, 32'h08, 32'h20090002);
        addv(1,0,1, 32'h0C, 32'h012A5020, 1,1,1, 1, 32'h0C, 32'h012A5020);
        addv(0,0,1, 32'h00, 32'h00000000, 0,1,0, 0, 0, 0);
        addv(1,0,0, 32'h10, 32'h00000011, 1,1,1, 1, 32'h10, 32'h11);
        addv(1,0,0, 32'h14, 32'h00000022, 1,0,2, 1, 32'h10, 32'h11);
        addv(1,0,0, 32'h18, 32'h00000033, 1,0,2, 1, 32'h10, 32'h11);
        addv(1,0,1, 32'h1C, 32'h00000099, 1,1,1, 1, 32'h14, 32'h22);
        addv(0,0,1, 32'h00, 32'h00000000, 0,1,0, 0, 0, 0);
        addv(1,0,0, 32'h20, 32'h00000044, 1,1,1, 1, 32'h20, 32'h44);
        addv(1,0,1, 32'h24, 32'h00000055, 1,1,1, 1, 32'h24, 32'h55);
        addv(1,0,0, 32'h28, 32'h00000066, 1,0,2, 1, 32'h24, 32'h55);
        addv(1,1,1, 32'h40, 32'h00000077, 0,1,0, 0, 0, 0);
        addv(1,0,0, 32'h44, 32'h00000088, 1,1,1, 1, 32'h44, 32'h88);
        addv(0,0,1, 32'h00, 32'h00000000, 0,1,0, 0, 0, 0);

        model_reset();
        repeat (2) @(negedge clock);
        check_dut();
        reset_n = 1;
        for (int k = 0; k < 5; k++) tick();

        foreach (tbl[k]) begin
            drive(tbl[k].hit, tbl[k].flush, tbl[k].ordy, tbl[k].pc, tbl[k].ins);
            tick();
            chk($sformatf("tbl%0d.hit_out", k), ho2, tbl[k].e_hit);
            chk($sformatf("tbl%0d.count", k), c2, tbl[k].e_cnt);
            chk($sformatf("tbl%0d.in_ready", k), ir2, tbl[k].e_ir);
            if (tbl[k].chk_data) begin
                chk($sformatf("tbl%0d.pc", k), pc2, tbl[k].e_pc);
                chk($sformatf("tbl%0d.instr", k), in2, tbl[k].e_ins);
            end
        end

        // DEPTH=4 wrap: preload 3, then 10 push+pop cycles, then drain
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 32'h100 + 4 * k, 32'hA000 + k);
            tick();
        end
        for (int k = 3; k < 13; k++) begin
            drive(1, 0, 1, 32'h100 + 4 * k, 32'hA000 + k);
            tick();
        end
        drive(0, 0, 1, 0, 0);
        repeat (5) tick();

        // asynchronous reset between edges with both buffers holding 2
        drive(1, 0, 0, 32'h200, 32'hB0);
        tick();
        drive(1, 0, 0, 32'h204, 32'hB1);
        tick();
        chk("pre_rst.count", c2, 2);
        drive(0, 0, 0, 0, 0);
        #2 reset_n = 0;
        #1;
        chk("async.u2.hit_out", ho2, 0);
        chk("async.u2.count", c2, 0);
        chk("async.u4.hit_out", ho4, 0);
        chk("async.u4.count", c4, 0);
        model_reset();
        @(negedge clock);
        check_dut();
        reset_n = 1;

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6, $urandom, $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
